hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage processor. It produces the E-stage forwarding selects, the load-use stall, and the branch flush. It also sequences a multi-cycle multiply held in E by driving the enable and clear of the F, D/E and E/M pipeline registers. It sits beside the datapath and drives `en = EnE` and `clr = FlushE` of the D/E register.

## Interface
Parameters:
- `MUL_LAT`, default 4: total cycles a multiply occupies E. Legal range 2..16.

Ports:
- `clk`: input, 1 bit. Pipeline clock.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `RA1D`, `RA2D`: input, 4 bits each. Source registers of the instruction in D.
- `RA1E`, `RA2E`: input, 4 bits each. Source registers of the instruction in E.
- `WA3E`, `WA3M`, `WA3W`: input, 4 bits each. Destination register in E, M and W.
- `RegWriteM`, `RegWriteW`: input, 1 bit each. Destination write enable in M and W.
- `MemtoRegE`: input, 1 bit. The instruction in E is a load.
- `BranchTakenE`: input, 1 bit. A branch resolved taken in E.
- `MulStartE`: input, 1 bit. The instruction in E is a multi-cycle multiply. This stays high for as long as the instruction is held in E.
- `ForwardAE`, `ForwardBE`: output, 2 bits each. Operand select: 00 = register file, 01 = W result, 10 = M ALU result.
- `StallF`, `StallD`: output, 1 bit each. Hold the PC and the F/D register.
- `EnE`: output, 1 bit. D/E register enable (the inverse of the E stall).
- `FlushD`, `FlushE`, `FlushM`: output, 1 bit each. Clear of F/D, D/E and E/M.
- `MulBusy`: output, 1 bit. FSM is in BUSY.
- `MulDoneE`: output, 1 bit. Last cycle of the multiply in E.

## Operation
Forwarding (combinational), shown for A; B is identical using RA2E:
- Output 10 if `RegWriteM` and `WA3M == RA1E`.
- Otherwise 01 if `RegWriteW` and `WA3W == RA1E`.
- Otherwise 00.
- M has priority over W.
- R15 (4'hF) is never forwarded; it always selects 00.

Load-use:
- `LdStall = MemtoRegE & (RA1D == WA3E | RA2D == WA3E)`, unless `BranchTakenE` is high.

Branch:
- `BranchTakenE` sets `FlushD = 1` and `FlushE = 1`.
- It masks `LdStall`, so the squashed D instruction never stalls.

Multiply FSM, state plus a 4-bit counter `cnt`:
- IDLE, `MulStartE = 1`: `MulStall = 1`, load `cnt <= MUL_LAT-2`, go to BUSY.
- BUSY, `cnt != 0`: `MulStall = 1`, `cnt <= cnt-1`.
- BUSY, `cnt == 0`: `MulStall = 0`, `MulDoneE = 1`, go to IDLE.
- `MulStartE` is ignored in BUSY; it is the same instruction still held in E.

Outputs:
- `StallF = StallD = LdStall | MulStall`.
- `EnE = ~MulStall`.
- `FlushE = (LdStall | BranchTakenE) & ~MulStall`.
- `FlushM = MulStall`: a bubble enters M each held cycle.
- `FlushD = BranchTakenE`.

## Timing
- Forwarding, load-use and branch outputs are purely combinational from the current inputs, with 0-cycle latency.
- The multiply holds E for exactly `MUL_LAT` cycles and `MulStall` is high for `MUL_LAT-1` cycles. `MulStall` is Mealy-asserted in the start cycle.
- On the release cycle, E advances on the next edge. `MulStartE` is still high on the release cycle and causes no restart.
- Back-to-back multiplies: a second multiply arriving in E the cycle after release starts a fresh sequence with no gap.
- Reset is asynchronous:
  - State goes to IDLE, `cnt` to 0, `MulBusy` and `MulDoneE` to 0, and `MulStall` drops immediately.
  - With all inputs at 0: Forward = 00, stalls = 0, `EnE = 1`, flushes = 0.
- Reset mid-multiply aborts the sequence. After reset deasserts, a still-high `MulStartE` starts a new full sequence.
- Simultaneous events:
  - `BranchTakenE` cannot coexist with `MulStartE`, since both would be the instruction in E.
  - If both are driven anyway, `MulStall` wins, so `EnE = 0` and `FlushE = 0`, and `FlushD` still follows `BranchTakenE`.

## Test plan
- Forwarding priority:
  - `RA1E = 3`, `WA3M = 3`, `WA3W = 3`, both write enables high gives `ForwardAE = 10`.
  - Dropping `RegWriteM` gives 01.
  - `RA1E = 15` gives 00.
- Load-use: `MemtoRegE = 1`, `WA3E = 5`, `RA2D = 5` gives `StallF = StallD = 1`, `FlushE = 1`, `EnE = 1`. Adding `BranchTakenE = 1` gives stalls 0 and `FlushD = FlushE = 1`.
- Multiply, `MUL_LAT = 4`: `MulStartE` held for 4 cycles gives `EnE` low for cycles 0–2 and high on cycle 3. `FlushM` is high for cycles 0–2, and `MulDoneE = 1` only on cycle 3.
- `MUL_LAT = 2`, back-to-back multiplies: `EnE` pattern 0,1,0,1, and `MulBusy` high on cycles 1 and 3.
- Reset mid-multiply: assert `reset` in cycle 1 of a 4-cycle multiply; `EnE` returns to 1 immediately. Release reset with `MulStartE = 1`; `EnE` stays low for 3 more cycles.
- Power-on reset: all outputs at their reset values with inputs at 0, with no X on any output.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage pipeline: E-stage forwarding, load-use stall,
// branch flush and the stall/flush sequencing of a multi-cycle multiply held in E.
module hazard_unit #(
    parameter int MUL_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] RA1D,
    input  logic [3:0] RA2D,
    input  logic [3:0] RA1E,
    input  logic [3:0] RA2E,
    input  logic [3:0] WA3E,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       BranchTakenE,
    input  logic       MulStartE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       EnE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       MulBusy,
    output logic       MulDoneE
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] LOAD_CNT = 4'(MUL_LAT - 2);

    state_t     state;
    logic [3:0] cnt;
    logic       mul_stall;
    logic       ld_stall;

    // R15 is the PC and never comes from the bypass network; M beats W.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] ra,
        input logic [3:0] wa_m,
        input logic [3:0] wa_w,
        input logic       we_m,
        input logic       we_w
    );
        if (ra == 4'hF)
            return 2'b00;
        else if (we_m && (wa_m == ra))
            return 2'b10;
        else if (we_w && (wa_w == ra))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        ForwardAE = fwd_sel(RA1E, WA3M, WA3W, RegWriteM, RegWriteW);
        ForwardBE = fwd_sel(RA2E, WA3M, WA3W, RegWriteM, RegWriteW);
    end

    // NOTE: mul_stall is gated by reset so it drops the instant reset rises, even though
    // the IDLE-with-start term is Mealy and MulStartE may still be high.
    always_comb begin
        mul_stall = ~reset & (((state == IDLE) && MulStartE) || ((state == BUSY) && (cnt != 4'd0)));
        ld_stall  = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E)) & ~BranchTakenE;
    end

    always_comb begin
        StallF = ld_stall | mul_stall;
        StallD = ld_stall | mul_stall;
        EnE    = ~mul_stall;
        FlushD = BranchTakenE;
        FlushE = (ld_stall | BranchTakenE) & ~mul_stall;
        FlushM = mul_stall;
    end

    // MulBusy and MulDoneE are registered alongside the state so they change only on edges.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            MulBusy  <= 1'b0;
            MulDoneE <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MulStartE) begin
                        state    <= BUSY;
                        cnt      <= LOAD_CNT;
                        MulBusy  <= 1'b1;
                        MulDoneE <= (LOAD_CNT == 4'd0);
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt      <= cnt - 4'd1;
                        MulDoneE <= (cnt == 4'd1);
                    end else begin
                        state    <= IDLE;
                        MulBusy  <= 1'b0;
                        MulDoneE <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= 4'd0;
                    MulBusy  <= 1'b0;
                    MulDoneE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (MUL_LAT 4 and 2) on shared inputs, directed steps
// then random cycles, compared to a model that tracks remaining multiply cycles in E.
module tb_hazard_unit;

    logic       clk;
    logic       reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MulStartE;

    logic [1:0] fa4, fb4, fa2, fb2;
    logic       sf4, sd4, en4, fd4, fe4, fm4, bz4, dn4;
    logic       sf2, sd2, en2, fd2, fe2, fm2, bz2, dn2;

    int checks = 0;
    int errors = 0;
    int rem4   = 0;
    int rem2   = 0;

    hazard_unit #(.MUL_LAT(4)) u4 (
        .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
        .ForwardAE(fa4), .ForwardBE(fb4), .StallF(sf4), .StallD(sd4), .EnE(en4),
        .FlushD(fd4), .FlushE(fe4), .FlushM(fm4), .MulBusy(bz4), .MulDoneE(dn4)
    );

    hazard_unit #(.MUL_LAT(2)) u2 (
        .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
        .ForwardAE(fa2), .ForwardBE(fb2), .StallF(sf2), .StallD(sd2), .EnE(en2),
        .FlushD(fd2), .FlushE(fe2), .FlushM(fm2), .MulBusy(bz2), .MulDoneE(dn2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
        if (ra != 4'hF && RegWriteM && WA3M == ra) return 2'b10;
        if (ra != 4'hF && RegWriteW && WA3W == ra) return 2'b01;
        return 2'b00;
    endfunction

    // rem = cycles the current multiply still occupies E, counted before this cycle's start.
    function automatic int cur_rem(input int rem, input int lat);
        if (reset) return 0;
        return (rem == 0 && MulStartE) ? lat : rem;
    endfunction

    function automatic logic [15:0] ref_out(input int rem, input int lat);
        logic stall, ld;
        stall = cur_rem(rem, lat) > 1;
        ld    = MemtoRegE && (RA1D == WA3E || RA2D == WA3E) && !BranchTakenE;
        return {2'b00, ref_fwd(RA1E), ref_fwd(RA2E), ld | stall, ld | stall, !stall,
                BranchTakenE, (ld | BranchTakenE) & !stall, stall, rem > 0, rem == 1};
    endfunction

    function automatic int next_rem(input int rem, input int lat);
        int c;
        c = cur_rem(rem, lat);
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic settle();
        if (reset) begin
            rem4 = 0;
            rem2 = 0;
        end
        #3;
        check("all_lat4", {2'b00, fa4, fb4, sf4, sd4, en4, fd4, fe4, fm4, bz4, dn4}, ref_out(rem4, 4));
        check("all_lat2", {2'b00, fa2, fb2, sf2, sd2, en2, fd2, fe2, fm2, bz2, dn2}, ref_out(rem2, 2));
    endtask

    task automatic advance();
        rem4 = next_rem(rem4, 4);
        rem2 = next_rem(rem2, 2);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MulStartE} = '0;
    endtask

    function automatic logic [3:0] rnd_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'hF : 4'(r);
    endfunction

    initial begin
        clear_inputs();
        reset = 1'b1;

        // Power-on reset with inputs idle.
        settle();
        check("por_lat4", {2'b00, fa4, fb4, sf4, sd4, en4, fd4, fe4, fm4, bz4, dn4}, 16'h0020);
        check("por_lat2", {2'b00, fa2, fb2, sf2, sd2, en2, fd2, fe2, fm2, bz2, dn2}, 16'h0020);
        advance();
        reset = 1'b0;

        // Forwarding priority and R15 exclusion.
        RA1E = 4'd3; WA3M = 4'd3; WA3W = 4'd3; RegWriteM = 1'b1; RegWriteW = 1'b1;
        settle(); check("fwd_m_prio", fa4, 2'b10); advance();
        RegWriteM = 1'b0;
        settle(); check("fwd_w", fa4, 2'b01); advance();
        RA1E = 4'hF; WA3M = 4'hF; WA3W = 4'hF; RegWriteM = 1'b1;
        settle(); check("fwd_r15", fa4, 2'b00); advance();
        clear_inputs();

        // Load-use, then masked by a taken branch.
        MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
        settle();
        check("ld_stall", {sf4, sd4, fe4, en4}, 4'b1111);
        advance();
        BranchTakenE = 1'b1;
        settle();
        check("ld_branch", {sf4, sd4, fd4, fe4}, 4'b0011);
        advance();
        clear_inputs();

        // Multiply held 4 cycles: lat-4 sequence and back-to-back lat-2 sequences.
        MulStartE = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            check("mul4_en", en4, (c == 3));
            check("mul4_flushm", fm4, (c != 3));
            check("mul4_done", dn4, (c == 3));
            check("mul2_en", en2, (c % 2 == 1));
            check("mul2_busy", bz2, (c % 2 == 1));
            advance();
        end
        MulStartE = 1'b0;
        settle();
        check("mul4_idle", {bz4, en4}, 2'b01);
        advance();

        // Reset in cycle 1 of a lat-4 multiply, then restart with MulStartE still high.
        MulStartE = 1'b1;
        settle(); advance();
        settle(); check("rst_pre", en4, 1'b0);
        reset = 1'b1;
        settle(); check("rst_async", en4, 1'b1);
        advance();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            check("rst_restart", en4, (c == 3));
            advance();
        end
        clear_inputs();
        advance();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            RA1D = rnd_reg(); RA2D = rnd_reg(); RA1E = rnd_reg(); RA2E = rnd_reg();
            WA3E = rnd_reg(); WA3M = rnd_reg(); WA3W = rnd_reg();
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            MemtoRegE    = 1'($urandom_range(0, 2) == 0);
            BranchTakenE = 1'($urandom_range(0, 4) == 0);
            MulStartE    = 1'($urandom_range(0, 2) == 0);
            reset        = 1'($urandom_range(0, 39) == 0);
            settle();
            advance();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
